// File: rtl/lif_step_sequencer.sv
// Timestep sequencer: sweeps the pre- and postsynaptic counters,
// drains the output spike FIFO and reports completion.
module lif_step_sequencer #(
  parameter int TIMEOUT  = 1024,
  parameter int TS_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic                abort_i,
  input  logic                presyn_done_i,
  input  logic                postsyn_done_i,
  input  logic                fifo_empty_i,
  output logic [2:0]          presyn_cntl_o,
  output logic [2:0]          postsyn_cntl_o,
  output logic                fifo_rd_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [TS_WIDTH-1:0] timestep_o
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] C_IDLE  = 3'b000;
  localparam logic [2:0] C_RUN   = 3'b001;
  localparam logic [2:0] C_PAUSE = 3'b010;
  localparam logic [2:0] C_RST   = 3'b011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE_RST,
    S_PRE_RUN,
    S_POST_RST,
    S_POST_RUN,
    S_DRAIN,
    S_DONE,
    S_ABORT,
    S_ERR
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [WW-1:0] wd;
  logic          wd_last;
  logic          timed;
  logic          in_run;
  logic          rd_q;

  assign wd_last = (wd == WW'(TIMEOUT - 1));
  assign timed   = wd_last && !pause_i;
  assign in_run  = (state == S_PRE_RUN) ||
                   (state == S_POST_RUN) ||
                   (state == S_DRAIN);

  // Exit conditions win over the watchdog on the same edge.
  always_comb begin
    nxt = state;
    if (state != S_IDLE && abort_i) begin
      nxt = S_ABORT;
    end else begin
      unique case (state)
        S_IDLE:     if (start_i) nxt = S_PRE_RST;
        S_PRE_RST:  nxt = S_PRE_RUN;
        S_PRE_RUN: begin
          if (presyn_done_i) nxt = S_POST_RST;
          else if (timed)    nxt = S_ERR;
        end
        S_POST_RST: nxt = S_POST_RUN;
        S_POST_RUN: begin
          if (postsyn_done_i) nxt = S_DRAIN;
          else if (timed)     nxt = S_ERR;
        end
        S_DRAIN: begin
          if (fifo_empty_i) nxt = S_DONE;
          else if (timed)   nxt = S_ERR;
        end
        S_DONE:     nxt = S_IDLE;
        S_ABORT:    nxt = S_IDLE;
        S_ERR:      nxt = S_ERR;
        default:    nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= S_IDLE;
      wd             <= '0;
      presyn_cntl_o  <= C_IDLE;
      postsyn_cntl_o <= C_IDLE;
      rd_q           <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      timestep_o     <= '0;
    end else begin
      state <= nxt;

      if (nxt != state)
        wd <= '0;
      else if (in_run && !pause_i)
        wd <= wd + WW'(1);

      presyn_cntl_o  <= C_IDLE;
      postsyn_cntl_o <= C_IDLE;
      rd_q           <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= (nxt != S_IDLE);
      err_o          <= (nxt == S_ERR);

      unique case (nxt)
        S_PRE_RST:  presyn_cntl_o <= C_RST;
        S_PRE_RUN:  presyn_cntl_o <= pause_i ? C_PAUSE : C_RUN;
        S_POST_RST: postsyn_cntl_o <= C_RST;
        S_POST_RUN: postsyn_cntl_o <= pause_i ? C_PAUSE : C_RUN;
        S_DRAIN:    rd_q <= !pause_i;
        S_DONE: begin
          done_o     <= 1'b1;
          timestep_o <= timestep_o + TS_WIDTH'(1);
        end
        S_ABORT, S_ERR: begin
          presyn_cntl_o  <= C_RST;
          postsyn_cntl_o <= C_RST;
        end
        default: ;
      endcase
    end
  end

  // Empty gating stops the read the moment the last word leaves.
  assign fifo_rd_o = rd_q && !fifo_empty_i;

endmodule

// File: tb/tb_lif_step_sequencer.sv
// Directed bench for lif_step_sequencer with a small FIFO model
// (TIMEOUT=16, TS_WIDTH=4).
module tb_lif_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       presyn_done = 1'b0;
  logic       postsyn_done = 1'b0;
  logic       fifo_empty;
  logic [2:0] presyn;
  logic [2:0] postsyn;
  logic       fifo_rd;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] ts;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int rd_loaded = 0;
  int rds;
  int dns;

  lif_step_sequencer #(
    .TIMEOUT (16),
    .TS_WIDTH(4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .pause_i       (pause),
    .abort_i       (abort),
    .presyn_done_i (presyn_done),
    .postsyn_done_i(postsyn_done),
    .fifo_empty_i  (fifo_empty),
    .presyn_cntl_o (presyn),
    .postsyn_cntl_o(postsyn),
    .fifo_rd_o     (fifo_rd),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .timestep_o    (ts)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fifo_rd) rd_cnt <= rd_cnt + 1;

  assign fifo_empty = (rd_cnt >= rd_loaded);

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int lim,
                           output int nrd, output int ndn);
    nrd = 0;
    ndn = 0;
    for (int i = 0; i < lim; i++) begin
      step;
      if (fifo_rd) nrd++;
      if (done) ndn++;
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  task automatic run_min(input string tag);
    int r;
    int d;
    start = 1'b1;
    step;
    start = 1'b0;
    wait_idle(tag, 20, r, d);
    chk({tag, "_done"}, d, 1);
  endtask

  initial begin
    // reset values
    #1 rst = 1'b0;
    #1;
    chk("rst_pre", presyn, 0);
    chk("rst_post", postsyn, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ts", ts, 0);
    step;
    step;
    rst = 1'b1;
    step;

    // t1: presyn 10 cycles, postsyn 5 cycles, 3 FIFO words
    rd_loaded = rd_cnt + 3;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("t1_pre_rst", presyn, 3);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      step;
      chk("t1_pre_run", presyn, 1);
    end
    presyn_done = 1'b1;
    step;
    presyn_done = 1'b0;
    chk("t1_post_rst", postsyn, 3);
    chk("t1_pre_off", presyn, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t1_post_run", postsyn, 1);
    end
    postsyn_done = 1'b1;
    wait_idle("t1_idle", 20, rds, dns);
    postsyn_done = 1'b0;
    chk("t1_rd_cycles", rds, 3);
    chk("t1_done_pulses", dns, 1);
    chk("t1_ts", ts, 1);

    // t2: pause 4 cycles mid PRE_RUN, watchdog frozen
    rd_loaded = rd_cnt;
    postsyn_done = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("t2_pre_rst", presyn, 3);
    step;
    chk("t2_run_a", presyn, 1);
    step;
    chk("t2_run_b", presyn, 1);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("t2_paused", presyn, 2);
    end
    pause = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step;
      chk("t2_resumed", presyn, 1);
      chk("t2_no_err", err, 0);
    end
    presyn_done = 1'b1;
    wait_idle("t2_idle", 20, rds, dns);
    presyn_done = 1'b0;
    postsyn_done = 1'b0;
    chk("t2_done_pulses", dns, 1);
    chk("t2_ts", ts, 2);

    // t3: watchdog timeout in PRE_RUN, then abort
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step;
      chk("t3_pre_run", presyn, 1);
      chk("t3_err_low", err, 0);
    end
    step;
    chk("t3_err", err, 1);
    chk("t3_err_pre", presyn, 3);
    chk("t3_err_post", postsyn, 3);
    chk("t3_err_rd", fifo_rd, 0);
    start = 1'b1;
    step;
    step;
    start = 1'b0;
    chk("t3_err_sticky", err, 1);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("t3_abort_pre", presyn, 3);
    chk("t3_abort_post", postsyn, 3);
    chk("t3_abort_err", err, 0);
    chk("t3_abort_done", done, 0);
    step;
    chk("t3_idle", busy, 0);
    chk("t3_idle_pre", presyn, 0);
    chk("t3_ts", ts, 2);

    // t4: abort in POST_RUN, start while busy ignored
    presyn_done = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    chk("t4_post_rst", postsyn, 3);
    step;
    chk("t4_post_run", postsyn, 1);
    start = 1'b1;
    step;
    chk("t4_post_run2", postsyn, 1);
    start = 1'b0;
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("t4_abort_pre", presyn, 3);
    chk("t4_abort_post", postsyn, 3);
    chk("t4_abort_done", done, 0);
    step;
    chk("t4_idle", busy, 0);
    chk("t4_idle_post", postsyn, 0);
    chk("t4_no_done", done, 0);
    step;
    step;
    chk("t4_not_queued", busy, 0);
    chk("t4_ts", ts, 2);

    // t5: timestep wrap on the 16th completion
    postsyn_done = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_min("t5_run");
      chk("t5_ts", ts, (i + 3) % 16);
    end
    chk("t5_wrap", ts, 0);

    // t6: async reset while reading in DRAIN
    rd_loaded = rd_cnt + 5;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd) break;
      step;
    end
    chk("t6_rd_up", fifo_rd, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rd", fifo_rd, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pre", presyn, 0);
    chk("t6_post", postsyn, 0);
    chk("t6_ts", ts, 0);
    step;
    rst = 1'b1;
    presyn_done = 1'b0;
    postsyn_done = 1'b0;
    step;
    chk("t6_stay_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
